// File: rtl/automate_pkg.sv
// Shared definitions for the table-driven control automaton: controller states,
// default geometry and transition-table entry layout helpers.
package automate_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } ctrl_t;

   localparam int unsigned DEF_SW = 3;
   localparam int unsigned DEF_XW = 3;
   localparam int unsigned DEF_YW = 5;

   // Entry layout is {next_state[SW], out[YW]}: outputs in the low bits.
   function automatic int unsigned out_lsb();
      return 0;
   endfunction

   function automatic int unsigned ns_lsb(input int unsigned yw);
      return yw;
   endfunction

   function automatic int unsigned entry_w(input int unsigned sw, input int unsigned yw);
      return sw + yw;
   endfunction

endpackage

// File: rtl/automate_prog_fsm_if.sv
// Configuration bus of the programmable automaton: table write port and
// the drop-notification pulse back to the writer.
interface automate_prog_fsm_if
   import automate_pkg::*;
#(
   parameter int unsigned SW = DEF_SW,
   parameter int unsigned XW = DEF_XW,
   parameter int unsigned YW = DEF_YW
);
   logic              cfg_we;
   logic [SW+XW-1:0]  cfg_addr;
   logic [SW+YW-1:0]  cfg_wdata;
   logic              cfg_err;

   modport master (output cfg_we, output cfg_addr, output cfg_wdata, input  cfg_err);
   modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata, output cfg_err);
endinterface

// File: rtl/automate_table.sv
// Transition table storage: one synchronous write port, one combinational
// read port, contents deliberately not reset so they survive a reset.
module automate_table #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 8
)(
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_comb rdata = mem[raddr];

endmodule

// File: rtl/automate_prog_fsm.sv
// Table-driven control automaton: next state and Mealy strobes are looked up
// from a loadable table indexed by {state, x}; reports done and step count.
module automate_prog_fsm
   import automate_pkg::*;
#(
   parameter int unsigned SW         = DEF_SW,
   parameter int unsigned XW         = DEF_XW,
   parameter int unsigned YW         = DEF_YW,
   parameter int unsigned INIT_STATE = 0,
   parameter int unsigned HALT_STATE = 4,
   parameter int unsigned CW         = 8
)(
   input  logic                clk,
   input  logic                res,
   input  logic                run,
   input  logic [XW-1:0]       x,
   output logic [YW-1:0]       t,
   output logic                ta,
   output logic [SW-1:0]       state,
   output logic [CW-1:0]       steps,
   automate_prog_fsm_if.slave  cfg
);
   localparam int unsigned     EW      = entry_w(SW, YW);
   localparam int unsigned     NS_LSB  = ns_lsb(YW);
   localparam int unsigned     OUT_LSB = out_lsb();
   localparam logic [SW-1:0]   INIT_S  = SW'(INIT_STATE);
   localparam logic [SW-1:0]   HALT_S  = SW'(HALT_STATE);

   ctrl_t          ctrl, ctrl_nxt;
   logic [EW-1:0]  e;
   logic [SW-1:0]  e_ns, state_nxt;
   logic [YW-1:0]  e_out;
   logic [CW-1:0]  steps_nxt;
   logic           ta_nxt, tbl_we, cfg_err_q;

   // Writes only land while idle; anything else is dropped and flagged.
   assign tbl_we      = cfg.cfg_we && (ctrl == IDLE);
   assign cfg.cfg_err = cfg_err_q;

   automate_table #(
      .AW (SW + XW),
      .DW (EW)
   ) u_table (
      .clk   (clk),
      .we    (tbl_we),
      .waddr (cfg.cfg_addr),
      .wdata (cfg.cfg_wdata),
      .raddr ({state, x}),
      .rdata (e)
   );

   assign e_ns  = e[NS_LSB +: SW];
   assign e_out = e[OUT_LSB +: YW];

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         ctrl      <= IDLE;
         state     <= INIT_S;
         steps     <= '0;
         ta        <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         ctrl      <= ctrl_nxt;
         state     <= state_nxt;
         steps     <= steps_nxt;
         ta        <= ta_nxt;
         cfg_err_q <= cfg.cfg_we && (ctrl != IDLE);
      end
   end

   always_comb begin
      ctrl_nxt  = ctrl;
      state_nxt = state;
      steps_nxt = steps;
      ta_nxt    = ta;
      t         = '0;
      unique case (ctrl)
         IDLE: begin
            if (run) begin
               ctrl_nxt  = RUN;
               state_nxt = INIT_S;
               steps_nxt = '0;
               ta_nxt    = 1'b0;
            end
         end
         RUN: begin
            t = e_out;
            // Dropping run suppresses the transition of this edge entirely.
            if (!run) begin
               ctrl_nxt  = IDLE;
               state_nxt = INIT_S;
               ta_nxt    = 1'b0;
            end else begin
               state_nxt = e_ns;
               if (steps != '1) steps_nxt = steps + CW'(1);
               if (e_ns == HALT_S) begin
                  ctrl_nxt = HALT;
                  ta_nxt   = 1'b1;
               end
            end
         end
         HALT: begin
            if (!run) begin
               ctrl_nxt  = IDLE;
               state_nxt = INIT_S;
               ta_nxt    = 1'b0;
            end
         end
         default: begin
            ctrl_nxt  = IDLE;
            state_nxt = INIT_S;
            ta_nxt    = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_automate_prog_fsm.sv
// Bench for automate_prog_fsm: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_automate_prog_fsm;
   localparam int INIT = 0;
   localparam int HALT = 4;

   logic       clk = 1'b0;
   logic       res, run, cfg_we;
   logic [2:0] x;
   logic [5:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [4:0] t, t2;
   logic       ta, ta2;
   logic [2:0] state, state2;
   logic [7:0] steps;
   logic [1:0] steps2;

   int n_pass = 0;
   int n_tot  = 0;

   automate_prog_fsm_if #(.SW(3), .XW(3), .YW(5)) cif  ();
   automate_prog_fsm_if #(.SW(3), .XW(3), .YW(5)) cif2 ();

   assign cif.cfg_we     = cfg_we;
   assign cif.cfg_addr   = cfg_addr;
   assign cif.cfg_wdata  = cfg_wdata;
   assign cif2.cfg_we    = cfg_we;
   assign cif2.cfg_addr  = cfg_addr;
   assign cif2.cfg_wdata = cfg_wdata;

   automate_prog_fsm #(.SW(3), .XW(3), .YW(5), .INIT_STATE(0), .HALT_STATE(4), .CW(8)) dut (
      .clk(clk), .res(res), .run(run), .x(x), .t(t), .ta(ta),
      .state(state), .steps(steps), .cfg(cif)
   );

   automate_prog_fsm #(.SW(3), .XW(3), .YW(5), .INIT_STATE(0), .HALT_STATE(4), .CW(2)) dut2 (
      .clk(clk), .res(res), .run(run), .x(x), .t(t2), .ta(ta2),
      .state(state2), .steps(steps2), .cfg(cif2)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode 0 = stopped, 1 = executing, 2 = finished.
   logic [7:0] m_tbl [64];
   int         m_mode, m_st, m_cnt;
   bit         m_ta, m_err;

   task automatic model_reset();
      m_mode = 0; m_st = INIT; m_cnt = 0; m_ta = 0; m_err = 0;
   endtask

   function automatic int m_t();
      logic [7:0] ent;
      ent = m_tbl[m_st * 8 + int'(x)];
      return (m_mode == 1) ? int'(ent[4:0]) : 0;
   endfunction

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   always @(posedge clk) begin : model_step
      int ns;
      if (res) begin
         m_err = cfg_we && (m_mode != 0);
         if (m_mode == 0) begin
            if (cfg_we) m_tbl[cfg_addr] = cfg_wdata;
            if (run) begin m_mode = 1; m_st = INIT; m_cnt = 0; end
         end else if (!run) begin
            m_mode = 0; m_st = INIT; m_ta = 0;
         end else if (m_mode == 1) begin
            ns    = int'(m_tbl[m_st * 8 + int'(x)]) / 32;
            m_st  = ns;
            m_cnt = m_cnt + 1;
            if (ns == HALT) begin m_mode = 2; m_ta = 1; end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      #1;
      chk("t",        int'(t),            m_t());
      chk("t_cw2",    int'(t2),           m_t());
      chk("ta",       int'(ta),           int'(m_ta));
      chk("ta_cw2",   int'(ta2),          int'(m_ta));
      chk("state",    int'(state),        m_st);
      chk("state_cw2",int'(state2),       m_st);
      chk("steps",    int'(steps),        sat(m_cnt, 255));
      chk("steps_cw2",int'(steps2),       sat(m_cnt, 3));
      chk("cfg_err",  int'(cif.cfg_err),  int'(m_err));
      chk("cfg_err2", int'(cif2.cfg_err), int'(m_err));
   end

   task automatic cfg_write(input logic [5:0] a, input logic [7:0] d);
      @(negedge clk); cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      @(negedge clk); cfg_we = 1'b0;
   endtask

   // Programmed sequence {0,1}->{1,01}, {1,1}->{4,12}; ends in HALT at negedge+2.
   task automatic run_seq(input string tag);
      @(negedge clk); run = 1'b1; x = 3'd1;
      #2 chk({tag, "_idle_t"}, int'(t), 0);
      @(negedge clk); #2 chk({tag, "_t1"}, int'(t), 'h01); chk({tag, "_s1"}, int'(state), 0);
      @(negedge clk); #2 chk({tag, "_t2"}, int'(t), 'h12); chk({tag, "_s2"}, int'(state), 1);
      @(negedge clk); #2 chk({tag, "_s3"}, int'(state), 4); chk({tag, "_ta"}, int'(ta), 1);
      chk({tag, "_steps"}, int'(steps), 2); chk({tag, "_t3"}, int'(t), 0);
   endtask

   initial begin
      res = 1'b0; run = 1'b1; x = 3'd7; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
      model_reset();
      repeat (3) @(negedge clk);
      #2 chk("rst_t", int'(t), 0); chk("rst_ta", int'(ta), 0);
      chk("rst_state", int'(state), 0); chk("rst_steps", int'(steps), 0);
      @(negedge clk); res = 1'b1; run = 1'b0;
      @(negedge clk); #2 chk("post_rst_state", int'(state), 0); chk("post_rst_t", int'(t), 0);

      for (int a = 0; a < 64; a++) cfg_write(6'(a), 8'h00);
      cfg_write(6'd1, {3'd1, 5'h01});
      cfg_write(6'd9, {3'd4, 5'h12});
      run_seq("load");
      @(negedge clk); run = 1'b0;
      @(negedge clk); #2 chk("stop_ta", int'(ta), 0);

      // Write attempted while running must be dropped.
      @(negedge clk); run = 1'b1; x = 3'd0;
      @(negedge clk); cfg_we = 1'b1; cfg_addr = 6'd1; cfg_wdata = {3'd0, 5'h1F};
      @(negedge clk); cfg_we = 1'b0; #2 chk("guard_err", int'(cif.cfg_err), 1);
      @(negedge clk); x = 3'd1; #2 chk("guard_err_clr", int'(cif.cfg_err), 0);
      chk("guard_entry", int'(t), 'h01);
      @(negedge clk); run = 1'b0; #2 chk("mid_state", int'(state), 1); chk("mid_t", int'(t), 'h12);
      @(negedge clk); #2 chk("stop_state", int'(state), 0); chk("stop_t", int'(t), 0);
      chk("stop_ta2", int'(ta), 0);

      cfg_write(6'd1, {3'd1, 5'h1F});
      #2 chk("idle_wr_err", int'(cif.cfg_err), 0);
      @(negedge clk); run = 1'b1; x = 3'd1;
      @(negedge clk); #2 chk("rerun_steps", int'(steps), 0); chk("rerun_t", int'(t), 'h1F);
      repeat (2) @(negedge clk);
      #2 chk("rerun_ta", int'(ta), 1);
      @(negedge clk); run = 1'b0;
      cfg_write(6'd1, {3'd1, 5'h01});

      // Asynchronous reset while halted, then replay from the retained table.
      run_seq("pre_ar");
      #1 cfg_we = 1'b0; res = 1'b0; model_reset();
      #1 chk("ar_ta", int'(ta), 0); chk("ar_state", int'(state), 0);
      @(negedge clk); res = 1'b1; run = 1'b0;
      run_seq("replay");
      @(negedge clk); run = 1'b0;

      // Self-loop on state 0 for six transitions.
      @(negedge clk); run = 1'b1; x = 3'd0;
      repeat (7) @(negedge clk);
      #2 chk("sat_cw2", int'(steps2), 3); chk("sat_cw8", int'(steps), 6);
      @(negedge clk); run = 1'b0;

      for (int a = 0; a < 64; a++)
         cfg_write(6'(a), {3'($urandom_range(0, 7)), 5'($urandom)});
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         x = 3'($urandom);
         if ($urandom_range(0, 15) == 0) run = ~run;
         cfg_we    = ($urandom_range(0, 7) == 0);
         cfg_addr  = 6'($urandom);
         cfg_wdata = 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #3 cfg_we = 1'b0; res = 1'b0; model_reset();
            @(negedge clk); res = 1'b1;
         end
      end
      @(negedge clk); #2;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
